// File: rtl/mad_io_bridge.sv
// Device-side bridge for the MAD core In/Out/Int pins: input FIFO, OUT register, IRQ pulser.
module mad_io_bridge #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned INT_PULSE = 1,
  parameter int unsigned INT_GAP   = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  output logic [15:0]              Proc_In,
  input  logic                     Proc_Rd,
  input  logic [15:0]              Proc_Out,
  input  logic                     Proc_Wr,
  output logic                     Int,
  input  logic [15:0]              Dev_In_Data,
  input  logic                     Dev_In_Valid,
  output logic                     Dev_In_Ready,
  output logic [15:0]              Dev_Out_Data,
  output logic                     Dev_Out_Valid,
  input  logic                     Dev_Out_Ready,
  input  logic                     Dev_Irq,
  output logic [$clog2(DEPTH):0]   In_Count,
  output logic                     Out_Overrun
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CMAX = (INT_PULSE > INT_GAP) ? INT_PULSE : INT_GAP;
  localparam int unsigned CW   = $clog2(CMAX) + 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          overrun_q, overrun_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic          pend_q, pend_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          int_q, int_d;
  logic          empty, full, push, pop, irq_edge;

  // FIFO status and handshakes; ready is held low while in reset
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == (AW+1)'(DEPTH));
    Dev_In_Ready = Rst && !full;
    push         = Dev_In_Valid && Dev_In_Ready;
    pop          = Proc_Rd && !empty;
    Proc_In      = empty ? 16'h0000 : mem_q[rd_ptr_q];
  end

  // FIFO next state: write at tail, advance head on pop, net occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = Dev_In_Data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // OUT register: a write always wins; overwriting an unaccepted word is sticky
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (Proc_Wr) begin
      out_data_d  = Proc_Out;
      out_valid_d = 1'b1;
      if (out_valid_q && !Dev_Out_Ready) begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && Dev_Out_Ready) begin
      out_valid_d = 1'b0;
    end
  end

  // IRQ synchronizer and rising-edge detect
  always_comb begin
    sync1_d  = Dev_Irq;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    irq_edge = sync2_q && !prev_q;
  end

  // Int FSM: pulse for INT_PULSE cycles, then hold low INT_GAP cycles; new edges set pending last
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = PULSE;
          pend_d  = 1'b0;
          cnt_d   = CW'(INT_PULSE - 1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CW'(INT_GAP - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (irq_edge) begin
      pend_d = 1'b1;
    end
    int_d = (state_d == PULSE);
  end

  // State registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      pend_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      int_q       <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      int_q       <= int_d;
    end
  end

  assign In_Count      = count_q;
  assign Dev_Out_Data  = out_data_q;
  assign Dev_Out_Valid = out_valid_q;
  assign Out_Overrun   = overrun_q;
  assign Int           = int_q;

endmodule

// File: doc/mad_io_bridge.md
Name: mad_io_bridge

Overview:
- Device-side counterpart of the processor's In/Out/Int pins; sits between the MAD RISC core and an external peripheral.
- Buffers device words into a FIFO that drives the core's In port and pops on each IN instruction.
- Captures OUT writes into a valid/ready output register toward the device.
- Converts device interrupt edges into a timed Int pulse with a minimum gap between pulses.

Parameters:
- DEPTH, 4, input FIFO entries; power of 2, at least 2.
- INT_PULSE, 1, cycles Int stays high per interrupt; at least 1.
- INT_GAP, 4, low cycles forced after each pulse before the next one; at least 1.

Ports:
- Clk  input  1  single clock; all state changes on its rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Proc_In  output  16  FIFO head word presented to the core In port; 0 when FIFO empty.
- Proc_Rd  input  1  core consumed Proc_In this cycle (IN executed).
- Proc_Out  input  16  core Out port value.
- Proc_Wr  input  1  core executed OUT this cycle.
- Int  output  1  interrupt to the core.
- Dev_In_Data  input  16  device word.
- Dev_In_Valid  input  1  device offers Dev_In_Data.
- Dev_In_Ready  output  1  bridge accepts; equals !full, forced 0 while Rst low.
- Dev_Out_Data  output  16  latched OUT word.
- Dev_Out_Valid  output  1  Dev_Out_Data pending.
- Dev_Out_Ready  input  1  device takes Dev_Out_Data.
- Dev_Irq  input  1  asynchronous device interrupt request, edge-significant.
- In_Count  output  clog2(DEPTH)+1  FIFO occupancy.
- Out_Overrun  output  1  sticky: an unread OUT word was overwritten.

Behaviour:
- Reset (Rst low, async): pointers, count, Dev_Out_Data, Dev_Out_Valid, Out_Overrun, Int, sync flops, pending and FSM all cleared. State goes to IDLE. Proc_In=0, In_Count=0. A reset mid-pulse drops Int immediately.
- FIFO push: on the edge where Dev_In_Valid && Dev_In_Ready. Dev_In_Ready is combinational !full, so no push occurs when full.
- FIFO pop: on the edge where Proc_Rd && !empty.
  - Proc_Rd while empty is ignored.
  - Proc_In is a combinational read of the head entry, gated to 0 when empty.
- Simultaneous push and pop:
  - Not empty (including full, where no push occurs anyway): count changes by +1 push, -1 pop, net per rules.
  - Empty: the pop is ignored, the push happens, and the new word appears on Proc_In after the edge.
- Pointers wrap modulo DEPTH. In_Count ranges 0..DEPTH.
- OUT path:
  - Proc_Wr loads Proc_Out into Dev_Out_Data and sets Dev_Out_Valid (1-cycle latency).
  - When Dev_Out_Valid && Dev_Out_Ready with no Proc_Wr, Dev_Out_Valid clears on that edge.
  - Proc_Wr in the same cycle as a handshake loads the new word, keeps Valid=1, no overrun.
  - Proc_Wr while Valid && !Ready overwrites Dev_Out_Data and sets Out_Overrun; it stays set until reset.
  - Dev_Out_Data stays stable while Valid && !Ready, except on overwrite.
- IRQ path:
  - Dev_Irq passes through a 2-flop synchronizer, then rising-edge detect against the previous synced value.
  - A detected edge sets a 1-bit pending flag; further edges while pending coalesce.
- Int FSM:
  - IDLE: if pending, go to PULSE, clear pending, load counter INT_PULSE-1.
  - PULSE: Int=1; decrement counter; at 0 go to GAP with counter INT_GAP-1.
  - GAP: Int=0; decrement; at 0 go to IDLE.
  - Int is registered and equals (state==PULSE).
  - Edges arriving in PULSE or GAP set pending and are serviced on return to IDLE.
  - Edge detected in the same cycle IDLE consumes pending: pending is cleared then re-set, i.e. set wins.
- IRQ latency: Dev_Irq high before edge 0 gives synced-high at edge 1, pending at edge 2, Int high after edge 3. Int lasts exactly INT_PULSE cycles.

Test Plan:
- Reset then push 0x1111, 0x2222, 0x3333, 0x4444 with Dev_In_Valid held → In_Count=4, Dev_In_Ready=0, Proc_In=0x1111. A fifth word 0x5555 is held off until Proc_Rd pops, then Proc_In=0x2222 and 0x5555 is accepted on the next edge.
- Empty FIFO: Proc_Rd=1 with push 0xABCD in the same cycle → In_Count=1, Proc_In=0xABCD afterward, no underflow.
- Proc_Wr 0x00FF with Dev_Out_Ready=0 → Valid=1, Data=0x00FF. Proc_Wr 0x0F0F next → Data=0x0F0F, Out_Overrun=1. Ready=1 with no write → Valid=0, Out_Overrun stays 1.
- Proc_Wr 0x1234 in the same cycle as a handshake on an older word → Data=0x1234, Valid stays 1, Out_Overrun=0.
- Defaults: Dev_Irq rises at t → Int high for exactly 1 cycle after the 3rd edge, then 4 low cycles. Two Dev_Irq pulses during GAP → exactly one further Int pulse.
- Assert Rst low while Int=1 and FIFO holds 2 words → Int, In_Count, Proc_In, Dev_Out_Valid go to 0 immediately without a clock edge.
